// File: rtl/md_unit_multicycle.sv
// Multi-cycle multiply/divide unit for the MIPS E stage: owns HI/LO, runs mult/div
// with fixed configurable latency, services mthi/mtlo and raises the D-stage MD stall.
module md_unit_multicycle #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       MDop,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             use_md,
    output logic             busy,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO,
    output logic             md_stall
);

    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic [WIDTH-1:0] phi_q, phi_d, plo_q, plo_d;
    logic             pwr_q, pwr_d;

    logic [2*WIDTH-1:0] prod_s, prod_u;
    logic [WIDTH-1:0]   b_nz, a_mag, b_mag, q_mag, r_mag, sq, sr, uq, ur;
    logic               b_zero;

    // Signed product via sign-extension to 2W: the low 2W bits of the product are exact.
    assign prod_s = {{WIDTH{A[WIDTH-1]}}, A} * {{WIDTH{B[WIDTH-1]}}, B};
    assign prod_u = {{WIDTH{1'b0}}, A} * {{WIDTH{1'b0}}, B};

    // Signed divide on magnitudes; MIN/-1 falls out naturally as LO=MIN, HI=0.
    // A zero divisor is replaced by 1 only to keep the datapath defined; its result is never committed.
    assign b_zero = (B == '0);
    assign b_nz   = b_zero ? WIDTH'(1) : B;
    assign a_mag  = A[WIDTH-1] ? (-A) : A;
    assign b_mag  = B[WIDTH-1] ? (-B) : b_nz;
    assign q_mag  = a_mag / b_mag;
    assign r_mag  = a_mag % b_mag;
    assign sq     = (A[WIDTH-1] ^ B[WIDTH-1]) ? (-q_mag) : q_mag;
    assign sr     = A[WIDTH-1] ? (-r_mag) : r_mag;
    assign uq     = A / b_nz;
    assign ur     = A % b_nz;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        phi_d   = phi_q;
        plo_d   = plo_q;
        pwr_d   = pwr_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (MDop <= 3'd3) begin
                        state_d = RUN;
                        pwr_d   = 1'b1;
                        case (MDop[1:0])
                            2'd0: begin
                                {phi_d, plo_d} = prod_s;
                                cnt_d          = CW'(MULT_CYCLES);
                            end
                            2'd1: begin
                                {phi_d, plo_d} = prod_u;
                                cnt_d          = CW'(MULT_CYCLES);
                            end
                            2'd2: begin
                                phi_d = sr;
                                plo_d = sq;
                                pwr_d = ~b_zero;
                                cnt_d = CW'(DIV_CYCLES);
                            end
                            default: begin
                                phi_d = ur;
                                plo_d = uq;
                                pwr_d = ~b_zero;
                                cnt_d = CW'(DIV_CYCLES);
                            end
                        endcase
                    end
                end else if (MDop == 3'd4) begin
                    hi_d = A;
                end else if (MDop == 3'd5) begin
                    lo_d = A;
                end
            end
            RUN: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = IDLE;
                    if (pwr_q) begin
                        hi_d = phi_q;
                        lo_d = plo_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            phi_q   <= '0;
            plo_q   <= '0;
            pwr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            phi_q   <= phi_d;
            plo_q   <= plo_d;
            pwr_q   <= pwr_d;
        end
    end

    assign busy     = (state_q == RUN);
    assign HI       = hi_q;
    assign LO       = lo_q;
    assign md_stall = use_md & (busy | start);

endmodule

// File: tb/tb_md_unit_multicycle.sv
// Scoreboard bench for md_unit_multicycle: a default 32-bit instance with directed ops,
// and a 16-bit fast instance (MULT=1, DIV=3) driven back-to-back.
module tb_md_unit_multicycle;

    typedef struct {
        string       nm;
        logic [31:0] ohi;
        logic [31:0] olo;
        logic [31:0] hi;
        logic [31:0] lo;
        int unsigned n;
    } exp_t;

    typedef struct {
        logic [2:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] hi;
        logic [15:0] lo;
        int unsigned n;
    } v16_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start0 = 1'b0, use0 = 1'b0;
    logic [2:0]  op0 = 3'd6;
    logic [31:0] a0 = '0, b0 = '0;
    logic        busy0, stall0;
    logic [31:0] hi0, lo0;
    logic        start1 = 1'b0, use1 = 1'b0;
    logic [2:0]  op1 = 3'd6;
    logic [15:0] a1 = '0, b1 = '0;
    logic        busy1, stall1;
    logic [15:0] hi1, lo1;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    exp_t        q0[$];
    exp_t        q1[$];
    logic [31:0] cur_hi = '0, cur_lo = '0;

    always #5 clk = ~clk;

    md_unit_multicycle dut0 (
        .clk(clk), .reset(reset), .start(start0), .MDop(op0), .A(a0), .B(b0),
        .use_md(use0), .busy(busy0), .HI(hi0), .LO(lo0), .md_stall(stall0)
    );

    md_unit_multicycle #(.WIDTH(16), .MULT_CYCLES(1), .DIV_CYCLES(3)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .MDop(op1), .A(a1), .B(b1),
        .use_md(use1), .busy(busy1), .HI(hi1), .LO(lo1), .md_stall(stall1)
    );

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, got, exp);
        end
    endtask

    // Monitors: count busy cycles, check HI/LO hold old values while busy, check commit on busy fall.
    int unsigned bc0 = 0, bc1 = 0;
    logic        pb0 = 1'b0, pb1 = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        if (busy0) begin
            bc0++;
            if (q0.size() != 0) begin
                chk({q0[0].nm, "_hold_hi"}, hi0, q0[0].ohi);
                chk({q0[0].nm, "_hold_lo"}, lo0, q0[0].olo);
            end
        end else if (pb0) begin
            if (q0.size() == 0) begin
                chk("dut0_unexpected_op", 32'd1, 32'd0);
            end else begin
                e = q0.pop_front();
                chk({e.nm, "_hi"}, hi0, e.hi);
                chk({e.nm, "_lo"}, lo0, e.lo);
                chk({e.nm, "_cycles"}, bc0, e.n);
            end
            bc0 = 0;
        end
        pb0 = busy0;
    end

    always @(negedge clk) begin
        exp_t e;
        if (busy1) begin
            bc1++;
            if (q1.size() != 0) begin
                chk({q1[0].nm, "_hold_hi"}, {16'h0, hi1}, q1[0].ohi);
                chk({q1[0].nm, "_hold_lo"}, {16'h0, lo1}, q1[0].olo);
            end
        end else if (pb1) begin
            if (q1.size() == 0) begin
                chk("dut1_unexpected_op", 32'd1, 32'd0);
            end else begin
                e = q1.pop_front();
                chk({e.nm, "_hi"}, {16'h0, hi1}, e.hi);
                chk({e.nm, "_lo"}, {16'h0, lo1}, e.lo);
                chk({e.nm, "_cycles"}, bc1, e.n);
            end
            bc1 = 0;
        end
        pb1 = busy1;
    end

    task automatic wait_idle0(input string nm);
        bit done = 1'b0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (!busy0) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) chk({nm, "_timeout"}, 32'd1, 32'd0);
    endtask

    task automatic expect0(input string nm, input logic [31:0] hi, input logic [31:0] lo,
                           input int unsigned n);
        exp_t e;
        e.nm = nm; e.ohi = cur_hi; e.olo = cur_lo; e.hi = hi; e.lo = lo; e.n = n;
        q0.push_back(e);
        cur_hi = hi;
        cur_lo = lo;
    endtask

    task automatic run_op(input string nm, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] hi, input logic [31:0] lo,
                          input int unsigned n, input bit stall_chk);
        expect0(nm, hi, lo, n);
        @(posedge clk); #1;
        start0 = 1'b1; op0 = op; a0 = a; b0 = b; use0 = stall_chk;
        if (stall_chk) begin
            #1 chk({nm, "_stall_launch"}, {31'd0, stall0}, 32'd1);
        end
        @(posedge clk); #1;
        start0 = 1'b0; op0 = 3'd6;
        if (stall_chk) begin
            for (int i = 0; i < int'(n); i++) begin
                @(negedge clk);
                chk($sformatf("%s_stall_c%0d", nm, i + 1), {31'd0, stall0}, 32'd1);
            end
            @(negedge clk);
            chk({nm, "_stall_drop"}, {31'd0, stall0}, 32'd0);
            use0 = 1'b0;
        end
        wait_idle0(nm);
    endtask

    task automatic mt_op(input string nm, input logic [2:0] op, input logic [31:0] a);
        @(posedge clk); #1;
        start0 = 1'b0; op0 = op; a0 = a;
        @(posedge clk); #1;
        op0 = 3'd6;
        if (op == 3'd4) cur_hi = a;
        else cur_lo = a;
        chk({nm, "_busy"}, {31'd0, busy0}, 32'd0);
        chk({nm, "_hi"}, hi0, cur_hi);
        chk({nm, "_lo"}, lo0, cur_lo);
    endtask

    initial begin
        v16_t        vec[$];
        v16_t        v;
        exp_t        e;
        int unsigned idx;
        int unsigned guard;
        logic [31:0] oh, ol;
        bit          drained;

        // Reset state with inputs low
        #2;
        chk("rst_busy", {31'd0, busy0}, 32'd0);
        chk("rst_hi", hi0, 32'd0);
        chk("rst_lo", lo0, 32'd0);
        chk("rst_stall", {31'd0, stall0}, 32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;

        mt_op("mthi_aa", 3'd4, 32'h0000_00AA);
        mt_op("mtlo_bb", 3'd5, 32'h0000_00BB);

        // Reset in the second busy cycle of mult 7*9: immediate clear, nothing committed later
        expect0("rst_mid", 32'h0, 32'h0, 1);
        @(posedge clk); #1;
        start0 = 1'b1; op0 = 3'd0; a0 = 32'd7; b0 = 32'd9;
        @(posedge clk); #1;
        start0 = 1'b0; op0 = 3'd6;
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        chk("rst_mid_busy_now", {31'd0, busy0}, 32'd0);
        chk("rst_mid_hi_now", hi0, 32'd0);
        chk("rst_mid_lo_now", lo0, 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        chk("rst_mid_late_busy", {31'd0, busy0}, 32'd0);
        chk("rst_mid_late_hi", hi0, 32'd0);
        chk("rst_mid_late_lo", lo0, 32'd0);

        run_op("mult_m1x2", 3'd0, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 5, 1'b0);
        run_op("multu_ffx2", 3'd1, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 32'hFFFF_FFFE, 5, 1'b0);
        run_op("div_m7_2", 3'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10, 1'b1);
        run_op("divu_7_2", 3'd3, 32'd7, 32'd2, 32'd1, 32'd3, 10, 1'b0);
        mt_op("mthi_11", 3'd4, 32'h11);
        mt_op("mtlo_22", 3'd5, 32'h22);
        run_op("div_by0", 3'd2, 32'd5, 32'd0, 32'h11, 32'h22, 10, 1'b0);
        run_op("div_min_m1", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 10, 1'b0);
        mt_op("mtlo_5", 3'd5, 32'd5);

        // start with MDop 6 / 4 must do nothing (no busy, no mthi)
        @(posedge clk); #1;
        start0 = 1'b1; op0 = 3'd6; a0 = 32'h1234;
        @(posedge clk); #1;
        op0 = 3'd4; a0 = 32'h77;
        chk("nop6_busy", {31'd0, busy0}, 32'd0);
        @(posedge clk); #1;
        start0 = 1'b0; op0 = 3'd6;
        chk("nop4_busy", {31'd0, busy0}, 32'd0);
        chk("nop4_hi", hi0, 32'h0);
        chk("nop4_lo", lo0, 32'd5);

        run_op("mult_7xm3", 3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 5, 1'b0);

        // multu 3*4 with an mthi and a new start injected mid-run: both ignored
        expect0("multu_ign", 32'h0, 32'hC, 5);
        @(posedge clk); #1;
        start0 = 1'b1; op0 = 3'd1; a0 = 32'd3; b0 = 32'd4;
        @(posedge clk); #1;
        start0 = 1'b0; op0 = 3'd4; a0 = 32'hDEAD;
        @(posedge clk); #1;
        start0 = 1'b1; op0 = 3'd2; a0 = 32'd100; b0 = 32'd3;
        @(posedge clk); #1;
        start0 = 1'b0; op0 = 3'd6;
        wait_idle0("multu_ign");

        // 16-bit instance, ops issued on every idle edge; junk start held during busy
        vec.push_back('{3'd0, 16'hFFFF, 16'h0002, 16'hFFFF, 16'hFFFE, 1});
        vec.push_back('{3'd1, 16'hFFFF, 16'hFFFF, 16'hFFFE, 16'h0001, 1});
        vec.push_back('{3'd2, 16'h8000, 16'hFFFF, 16'h0000, 16'h8000, 3});
        vec.push_back('{3'd3, 16'd100,  16'd7,    16'h0002, 16'h000E, 3});
        vec.push_back('{3'd2, 16'hFF9C, 16'd7,    16'hFFFE, 16'hFFF2, 3});
        vec.push_back('{3'd0, 16'h0100, 16'h0100, 16'h0001, 16'h0000, 1});
        vec.push_back('{3'd2, 16'h0009, 16'h0000, 16'h0001, 16'h0000, 3});
        idx = 0; guard = 0; oh = '0; ol = '0;
        while (idx < vec.size() && guard < 200) begin
            @(posedge clk); #1;
            guard++;
            if (!busy1) begin
                v = vec[idx];
                start1 = 1'b1; op1 = v.op; a1 = v.a; b1 = v.b;
                e.nm = $sformatf("w16_%0d", idx);
                e.ohi = oh; e.olo = ol; e.hi = {16'h0, v.hi}; e.lo = {16'h0, v.lo}; e.n = v.n;
                q1.push_back(e);
                oh = e.hi; ol = e.lo;
                idx++;
            end else begin
                start1 = 1'b1; op1 = 3'd0; a1 = 16'h1234; b1 = 16'h0005;
            end
        end
        if (idx < vec.size()) chk("w16_issue_timeout", 32'd1, 32'd0);
        @(posedge clk); #1;
        start1 = 1'b0; op1 = 3'd6;

        drained = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (q0.size() == 0 && q1.size() == 0 && !busy0 && !busy1) begin
                drained = 1'b1;
                break;
            end
        end
        if (!drained) chk("drain_timeout", 32'd1, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
